// File: rtl/image_uart_sender_if.sv
// Image memory read bus between the UART sender and the frame store.
// The sender issues readEnable/readAddr; the memory answers with readData
// one cycle later.
interface image_uart_sender_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int BIT_DEPTH  = 12
);
  logic                  readEnable;
  logic [ADDR_WIDTH-1:0] readAddr;
  logic [BIT_DEPTH-1:0]  readData;

  modport master (
    output readEnable,
    output readAddr,
    input  readData
  );

  modport slave (
    input  readEnable,
    input  readAddr,
    output readData
  );
endinterface

// File: rtl/image_uart_sender.sv
// Streams a full image frame out of a UART, one pixel at a time.
// Each pixel is fetched from memory and sent as two bytes: the high part
// (pixel bits above bit 7, zero-extended) followed by the low byte.
// Frames are 8N1, LSB first, back to back with no idle gap.
module image_uart_sender #(
  parameter int ADDR_WIDTH   = 19,
  parameter int BIT_DEPTH    = 12,
  parameter int NUM_PIXELS   = 307200,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic done,
  output logic busy,
  output logic tx,
  image_uart_sender_if.master memBus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]     BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PIXEL = ADDR_WIDTH'(NUM_PIXELS - 1);
  localparam logic [3:0]            STOP_BIT   = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SEND_HI,
    SEND_LO,
    DONE
  } stateType;

  stateType state;
  stateType nextState;

  logic [BAUD_W-1:0]     baudCount;
  logic [3:0]            bitIndex;
  logic [ADDR_WIDTH-1:0] pixelCount;
  logic [BIT_DEPTH-1:0]  pixelReg;

  logic        sending;
  logic        bitDone;
  logic        frameEnd;
  logic [15:0] pixelWide;
  logic [7:0]  txByte;
  logic [15:0] txFrame;

  // A UART bit ends on the last baud tick; a byte frame ends after the stop bit
  always_comb begin
    sending  = (state == SEND_HI) || (state == SEND_LO);
    bitDone  = sending && (baudCount == BAUD_LAST);
    frameEnd = bitDone && (bitIndex == STOP_BIT);
  end

  // State register, cleared straight to IDLE by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state sequencing: fetch, latch, two byte frames, repeat per pixel
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = FETCH;
      FETCH:   nextState = LATCH;
      LATCH:   nextState = SEND_HI;
      SEND_HI: if (frameEnd) nextState = SEND_LO;
      SEND_LO: begin
        if (frameEnd) begin
          nextState = (pixelCount == LAST_PIXEL) ? DONE : FETCH;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Pixel counter and pixel capture register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixelCount <= '0;
      pixelReg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) pixelCount <= '0;
        end
        LATCH: begin
          pixelReg <= memBus.readData;
        end
        SEND_LO: begin
          if (frameEnd && (pixelCount != LAST_PIXEL)) begin
            pixelCount <= pixelCount + ADDR_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Baud tick counter and bit position within the current byte frame
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      baudCount <= '0;
      bitIndex  <= '0;
    end else if (!sending) begin
      baudCount <= '0;
      bitIndex  <= '0;
    end else if (bitDone) begin
      baudCount <= '0;
      bitIndex  <= (bitIndex == STOP_BIT) ? 4'd0 : bitIndex + 4'd1;
    end else begin
      baudCount <= baudCount + BAUD_W'(1);
    end
  end

  // Serial line: start bit, 8 data bits LSB first, stop bit; high otherwise
  always_comb begin
    pixelWide = 16'(pixelReg);
    txByte    = (state == SEND_HI) ? pixelWide[15:8] : pixelWide[7:0];
    txFrame   = {6'b111111, txByte, 1'b0};
    tx        = sending ? txFrame[bitIndex] : 1'b1;
  end

  // Status and memory strobes decoded from state; the address only moves
  // when the counter does, so it holds between fetches
  always_comb begin
    done              = (state == DONE);
    busy              = (state != IDLE);
    memBus.readEnable = (state == FETCH);
    memBus.readAddr   = pixelCount;
  end

endmodule

// File: tb/tb_image_uart_sender.sv
// Directed bench for image_uart_sender with a 4-pixel frame and 4 clocks
// per UART bit. Outputs are logged one step after each rising edge, indexed
// from the edge that samples start, and then checked against hand-computed
// byte values and cycle positions.
module tb_image_uart_sender;

  localparam int ADDR_WIDTH   = 19;
  localparam int BIT_DEPTH    = 12;
  localparam int NUM_PIXELS   = 4;
  localparam int CLKS_PER_BIT = 4;
  localparam int MAXC         = 400;

  logic clock;
  logic reset;
  logic start;
  logic done;
  logic busy;
  logic tx;

  image_uart_sender_if #(.ADDR_WIDTH(ADDR_WIDTH), .BIT_DEPTH(BIT_DEPTH)) memIf ();

  image_uart_sender #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BIT_DEPTH   (BIT_DEPTH),
    .NUM_PIXELS  (NUM_PIXELS),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .done  (done),
    .busy  (busy),
    .tx    (tx),
    .memBus(memIf.master)
  );

  logic [BIT_DEPTH-1:0] mem [0:3];
  int expBytes [0:7];

  logic                  txLog   [0:MAXC-1];
  logic                  reLog   [0:MAXC-1];
  logic [ADDR_WIDTH-1:0] addrLog [0:MAXC-1];
  logic                  doneLog [0:MAXC-1];
  logic                  busyLog [0:MAXC-1];

  int checks   = 0;
  int failures = 0;

  // 100 MHz-style free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous image memory: data appears the cycle after the strobe
  always @(posedge clock) begin
    if (memIf.readEnable) memIf.readData <= mem[memIf.readAddr[1:0]];
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)",
               tag, actual, actual, expected, expected);
    end
  endtask

  // Raise start for one edge (or hold it), then log nCycles of outputs.
  // Index k is the value during the cycle after the k-th edge past the
  // start-sampling edge. pulseAt re-raises start for one edge mid-frame.
  task automatic applyStimulus(input int nCycles, input int pulseAt, input bit holdStart);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    if (!holdStart) start = 1'b0;
    for (int k = 0; k < nCycles; k++) begin
      if (k > 0) begin
        @(posedge clock);
        #1;
      end
      txLog[k]   = tx;
      reLog[k]   = memIf.readEnable;
      addrLog[k] = memIf.readAddr;
      doneLog[k] = done;
      busyLog[k] = busy;
      if (k == pulseAt) start = 1'b1;
      else if (!holdStart) start = 1'b0;
    end
  endtask

  // Check a logged single frame (340 cycles) against the expected stream
  task automatic checkFrame(input string tag);
    int reCount;
    int doneCount;
    int doneAt;
    int zeros;
    reCount   = 0;
    doneCount = 0;
    doneAt    = -1;
    zeros     = 0;
    for (int f = 0; f < 8; f++) begin
      int s;
      logic [7:0] got;
      s   = (f / 2) * 82 + 2 + (f % 2) * 40;
      got = 8'h00;
      for (int b = 0; b < 8; b++) got[b] = txLog[s + 4 * (b + 1) + 2];
      checkOutput($sformatf("%s_byte%0d", tag, f), int'(got), expBytes[f]);
    end
    checkOutput({tag, "_txBeforeStartBit"}, int'(txLog[1]), 1);
    for (int k = 2; k < 6; k++) if (txLog[k] == 1'b0) zeros++;
    checkOutput({tag, "_startBitLow4"}, zeros, 4);
    checkOutput({tag, "_stopBit"}, int'(txLog[39]), 1);
    checkOutput({tag, "_busyInFetch"}, int'(busyLog[0]), 1);
    for (int k = 0; k < 340; k++) begin
      if (reLog[k]) begin
        if (reCount < 4) begin
          checkOutput($sformatf("%s_readCycle%0d", tag, reCount), k, reCount * 82);
          checkOutput($sformatf("%s_readAddr%0d", tag, reCount), int'(addrLog[k]), reCount);
        end
        reCount++;
      end
      if (doneLog[k]) begin
        if (doneAt < 0) doneAt = k;
        doneCount++;
      end
    end
    checkOutput({tag, "_readCount"}, reCount, 4);
    checkOutput({tag, "_doneCount"}, doneCount, 1);
    checkOutput({tag, "_doneCycle"}, doneAt, 328);
    checkOutput({tag, "_idleAfterDone"}, int'(busyLog[335]), 0);
  endtask

  initial begin
    int badTx;
    int badDone;
    int badBusy;

    mem[0] = 12'hA5C;
    mem[1] = 12'h123;
    mem[2] = 12'hFFF;
    mem[3] = 12'h000;
    expBytes = '{8'h0A, 8'h5C, 8'h01, 8'h23, 8'h0F, 8'hFF, 8'h00, 8'h00};
    memIf.readData = '0;

    // Reset state
    reset = 1'b1;
    start = 1'b0;
    #1;
    checkOutput("rst_tx", int'(tx), 1);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_readEnable", int'(memIf.readEnable), 0);
    checkOutput("rst_readAddr", int'(memIf.readAddr), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Plain single frame
    applyStimulus(340, -1, 1'b0);
    checkFrame("single");

    // start re-raised mid-frame must change nothing
    applyStimulus(340, 100, 1'b0);
    checkFrame("ignored");

    // Reset in the middle of pixel 1's low byte
    applyStimulus(150, -1, 1'b0);
    @(posedge clock);
    #2;
    checkOutput("preReset_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    checkOutput("midReset_tx", int'(tx), 1);
    checkOutput("midReset_busy", int'(busy), 0);
    checkOutput("midReset_readEnable", int'(memIf.readEnable), 0);
    checkOutput("midReset_readAddr", int'(memIf.readAddr), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    badTx   = 0;
    badDone = 0;
    badBusy = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (tx !== 1'b1) badTx++;
      if (done !== 1'b0) badDone++;
      if (busy !== 1'b0) badBusy++;
    end
    checkOutput("postReset_txToggles", badTx, 0);
    checkOutput("postReset_donePulses", badDone, 0);
    checkOutput("postReset_busy", badBusy, 0);
    applyStimulus(340, -1, 1'b0);
    checkFrame("afterReset");

    // start held high: next frame starts from the IDLE cycle after DONE
    applyStimulus(340, -1, 1'b1);
    checkOutput("b2b_doneCycle", int'(doneLog[328]), 1);
    checkOutput("b2b_idleCycleBusy", int'(busyLog[329]), 0);
    checkOutput("b2b_noReadInIdle", int'(reLog[329]), 0);
    checkOutput("b2b_secondRead", int'(reLog[330]), 1);
    checkOutput("b2b_secondAddr", int'(addrLog[330]), 0);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/image_uart_sender.md
IMAGE_UART_SENDER -- requirements
Module: image_uart_sender

Interface
REQ-001 Parameters: name, default, meaning.
- ADDR_WIDTH, 19, image memory address width.
- BIT_DEPTH, 12, pixel width in bits; legal range 9..16.
- NUM_PIXELS, 307200, pixels per frame; addresses 0..NUM_PIXELS-1.
- CLKS_PER_BIT, 434, clock cycles per UART bit; 115200 baud at 50 MHz.

REQ-002 Ports: name, direction, width, meaning.
- clock, in, 1, single system clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-high reset.
- start, in, 1, level; sampled only in IDLE.
- done, out, 1, one-cycle pulse at frame completion.
- busy, out, 1, high in every state except IDLE.
- readEnable, out, 1, image memory read strobe.
- readAddr, out, ADDR_WIDTH, image memory read address.
- readData, in, BIT_DEPTH, pixel data, valid one cycle after the readEnable cycle.
- tx, out, 1, UART serial output; idles high.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, FETCH, LATCH, SEND_HI, SEND_LO, DONE.
REQ-004 IDLE: if start=1, go to FETCH with pixel counter = 0; otherwise stay in IDLE.
REQ-005 FETCH (1 cycle): readEnable=1, readAddr=pixel counter; next state LATCH.
REQ-006 LATCH (1 cycle): capture readData into the pixel register; readEnable=0; next state SEND_HI.
REQ-007 SEND_HI transmits one UART frame carrying {zero-extended pixel[BIT_DEPTH-1:8]} as an 8-bit byte.
REQ-008 SEND_LO transmits one UART frame carrying pixel[7:0].
REQ-009 UART frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Each bit is held exactly CLKS_PER_BIT cycles.
- Each frame is 10*CLKS_PER_BIT cycles long.
- No gap between the HI and LO frames.
REQ-010 After the SEND_LO stop bit completes:
- If pixel counter = NUM_PIXELS-1, go to DONE.
- Otherwise increment the counter and go to FETCH.
REQ-011 DONE (1 cycle): done=1; next state IDLE.
REQ-012 done SHALL rise exactly NUM_PIXELS*(2+20*CLKS_PER_BIT) cycles after the edge that samples start in IDLE.
REQ-013 start asserted in any non-IDLE state SHALL be ignored.
- start held high through DONE SHALL begin a new frame from the IDLE cycle that follows.
REQ-014 readEnable SHALL be high only in FETCH; readAddr SHALL hold its value outside FETCH.
REQ-015 tx SHALL be 1 in IDLE, FETCH, LATCH and DONE.
REQ-016 The pixel counter SHALL never exceed NUM_PIXELS-1 and SHALL be at least ADDR_WIDTH bits wide.
REQ-017 The baud counter SHALL count 0..CLKS_PER_BIT-1 and SHALL wrap to 0 on each bit boundary.
- The bit index SHALL count 0..9 and SHALL reset to 0 at the start of each frame.

Reset
REQ-018 reset=1 SHALL immediately (asynchronously) force all of the following:
- state=IDLE;
- tx=1, done=0, busy=0, readEnable=0;
- readAddr=0, pixel counter=0, baud counter=0, bit index=0, pixel register=0.
REQ-019 Reset asserted mid-transmission SHALL abort the frame with no further tx toggles.
- After reset releases, the block SHALL wait in IDLE for a new start.

Verification
REQ-020 Directed scenarios the bench SHALL cover (parameters NUM_PIXELS=4, CLKS_PER_BIT=4; memory returns 12'hA5C, 12'h123, 12'hFFF, 12'h000 at addresses 0..3):
- Single frame: start pulse -> tx carries bytes 0x0A, 0x5C, 0x01, 0x23, 0x0F, 0xFF, 0x00, 0x00, each frame 40 cycles; done pulses exactly once, 328 cycles after the start-sampling edge.
- Read timing: readEnable high for exactly 4 single cycles, with readAddr = 0, 1, 2, 3 in order; each pulse is 82 cycles after the previous one.
- Bit timing: the first start bit (tx=0) begins 2 cycles after the start-sampling edge and lasts 4 cycles; the stop bit reads 1.
- Start ignored: start pulsed at cycle 100 -> no change in the byte stream, and done is still at cycle 328.
- Reset mid-frame: reset asserted at cycle 150 -> tx=1 and busy=0 in the same cycle; no done pulse; a fresh start afterwards retransmits from address 0.
- Back-to-back: start held high continuously -> second frame's readEnable at address 0 occurs 2 cycles after done.
